// File: rtl/data_sram_responder.sv
// data_sram_responder: data-side SRAM-like slave model.
// Holds a word-addressed data array, applies byte-strobed stores and answers
// every accepted request with one in-order data_ok after LATENCY cycles.
// Loads sample the array at the accepting edge; the word travels through a
// small circular response queue together with its age counter.
module data_sram_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      wr,
    input  logic [31:0]               addr,
    input  logic [3:0]                wstrb,
    input  logic [31:0]               wdata,
    output logic                      addr_ok,
    output logic                      data_ok,
    output logic [31:0]               rdata,
    output logic [$clog2(QDEPTH):0]   outstanding
);

    localparam int             PW      = $clog2(QDEPTH);
    localparam logic [3:0]     AGE_MAX = 4'(LATENCY);
    localparam logic [3:0]     AGE_POP = 4'(LATENCY - 1);
    localparam logic [PW:0]    DEPTH   = (PW + 1)'(QDEPTH);

    // Data array; deliberately never reset so stores survive a reset pulse.
    logic [31:0] mem [0:(1 << AW) - 1];

    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    // Response queue storage.
    logic          q_load [QDEPTH];
    logic [31:0]   q_data [QDEPTH];
    logic [3:0]    q_age  [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic push;
    logic pop;

    assign idx              = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // Acceptance depends on occupancy only, never on req or a same-cycle pop.
    assign addr_ok     = (count < DEPTH);
    assign push        = req && addr_ok;
    assign pop         = (count != '0) && (q_age[head] >= AGE_POP);
    assign outstanding = count;

    // Response outputs come from queue state alone; stores answer with zero.
    always_comb begin
        data_ok = pop;
        rdata   = 32'h0;
        if (pop && q_load[head]) begin
            rdata = q_data[head];
        end
    end

    // Byte-strobed store into the array on an accepted write.
    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Queue bookkeeping: age all entries, push at tail, pop at head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_load[i] <= 1'b0;
                q_data[i] <= 32'h0;
                q_age[i]  <= 4'h0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_age[i] < AGE_MAX) begin
                    q_age[i] <= q_age[i] + 4'h1;
                end
            end
            if (push) begin
                q_load[tail] <= !wr;
                q_data[tail] <= wr ? 32'h0 : mem[idx];
                q_age[tail]  <= 4'h0;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder using three instances:
// u_a (LATENCY 2), u_b (LATENCY 8) and u_c (LATENCY 1), all QDEPTH 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle c" of a test is the period whose rising edge ends it.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;

    logic        aok_a, aok_b, aok_c;
    logic        dok_a, dok_b, dok_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic [2:0]  out_a, out_b, out_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.AW(10), .LATENCY(2), .QDEPTH(4)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .wr(wr), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_a), .data_ok(dok_a),
        .rdata(rd_a), .outstanding(out_a)
    );

    data_sram_responder #(.AW(10), .LATENCY(8), .QDEPTH(4)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .wr(wr), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_b), .data_ok(dok_b),
        .rdata(rd_b), .outstanding(out_b)
    );

    data_sram_responder #(.AW(10), .LATENCY(1), .QDEPTH(4)) u_c (
        .clk(clk), .reset(reset), .req(req_c), .wr(wr), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_c), .data_ok(dok_c),
        .rdata(rd_c), .outstanding(out_c)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (aok_a !== 1'b1)  begin errors++; $display("FAIL reset_addr_ok: got %b expected 1", aok_a); end
        checks++; if (dok_a !== 1'b0)  begin errors++; $display("FAIL reset_data_ok: got %b expected 0", dok_a); end
        checks++; if (rd_a !== 32'h0)  begin errors++; $display("FAIL reset_rdata: got %h expected 0", rd_a); end
        checks++; if (out_a !== 3'd0)  begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", out_a); end
        checks++; if (aok_b !== 1'b1 || aok_c !== 1'b1) begin errors++; $display("FAIL reset_addr_ok_bc: got %b%b expected 11", aok_b, aok_c); end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_load_roundtrip();
        u_a.mem[5] = 32'h8899AABB;
        for (int c = 0; c < 5; c++) begin
            req_a = (c == 0); wr = 1'b0; addr = 32'h14;
            @(negedge clk);
            if (c == 0) begin
                checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL rt_accept: got %b expected 1", aok_a); end
            end
            checks++;
            if (dok_a !== (c == 2)) begin errors++; $display("FAIL rt_data_ok c%0d: got %b expected %b", c, dok_a, (c == 2)); end
            if (c == 2) begin
                checks++; if (rd_a !== 32'h8899AABB) begin errors++; $display("FAIL rt_rdata: got %h expected 8899aabb", rd_a); end
                checks++; if (out_a !== 3'd1) begin errors++; $display("FAIL rt_out_c2: got %0d expected 1", out_a); end
            end
            if (c == 3) begin
                checks++; if (out_a !== 3'd0) begin errors++; $display("FAIL rt_out_c3: got %0d expected 0", out_a); end
            end
            next_cycle();
        end
        req_a = 1'b0;
    endtask

    task automatic test_byte_strobe();
        logic        s_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] s_addr [4] = '{32'h06, 32'h04, 32'h04, 32'h04};
        logic [3:0]  s_strb [4] = '{4'b0100, 4'h0, 4'h0, 4'h0};
        logic [31:0] s_data [4] = '{32'h00EE0000, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] e_rd   [4] = '{32'h0, 32'h11EE3344, 32'h0, 32'h11EE3344};
        u_a.mem[1] = 32'h11223344;
        for (int c = 0; c < 7; c++) begin
            req_a = (c < 4);
            if (c < 4) begin
                wr = s_wr[c]; addr = s_addr[c]; wstrb = s_strb[c]; wdata = s_data[c];
            end
            @(negedge clk);
            checks++;
            if (dok_a !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL strobe_data_ok c%0d: got %b expected %b", c, dok_a, (c >= 2 && c <= 5)); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (rd_a !== e_rd[c-2]) begin errors++; $display("FAIL strobe_rdata c%0d: got %h expected %h", c, rd_a, e_rd[c-2]); end
            end
            next_cycle();
        end
        req_a = 1'b0; wr = 1'b0; wstrb = 4'h0;
    endtask

    task automatic test_back_pressure();
        int  acc = 0;
        int  rsp = 0;
        logic exp_aok;
        logic exp_dok;
        for (int i = 0; i < 6; i++) u_b.mem[i] = 32'h100 + 32'(i);
        for (int c = 0; c < 20; c++) begin
            req_b = (acc < 6); wr = 1'b0; addr = 32'(acc * 4);
            @(negedge clk);
            if (c <= 10) begin
                exp_aok = (c <= 3) || (c == 9) || (c == 10);
                checks++;
                if (aok_b !== exp_aok) begin errors++; $display("FAIL bp_addr_ok c%0d: got %b expected %b", c, aok_b, exp_aok); end
            end
            exp_dok = (c >= 8 && c <= 11) || (c == 17) || (c == 18);
            checks++;
            if (dok_b !== exp_dok) begin errors++; $display("FAIL bp_data_ok c%0d: got %b expected %b", c, dok_b, exp_dok); end
            if (exp_dok) begin
                checks++;
                if (rd_b !== 32'h100 + 32'(rsp)) begin errors++; $display("FAIL bp_rdata c%0d: got %h expected %h", c, rd_b, 32'h100 + 32'(rsp)); end
                rsp++;
            end
            if (c == 8) begin
                checks++; if (out_b !== 3'd4) begin errors++; $display("FAIL bp_out_full: got %0d expected 4", out_b); end
            end
            if (req_b && aok_b) acc++;
            next_cycle();
        end
        req_b = 1'b0;
        checks++; if (out_b !== 3'd0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", out_b); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) u_c.mem[i] = 32'(i);
        for (int c = 0; c < 18; c++) begin
            req_c = (c < 16); wr = 1'b0; addr = 32'(c * 4);
            @(negedge clk);
            if (c < 16) begin
                checks++; if (aok_c !== 1'b1) begin errors++; $display("FAIL st_addr_ok c%0d: got %b expected 1", c, aok_c); end
            end
            checks++;
            if (dok_c !== (c >= 1 && c <= 16)) begin errors++; $display("FAIL st_data_ok c%0d: got %b expected %b", c, dok_c, (c >= 1 && c <= 16)); end
            if (c >= 1 && c <= 16) begin
                checks++;
                if (rd_c !== 32'(c - 1)) begin errors++; $display("FAIL st_rdata c%0d: got %h expected %h", c, rd_c, 32'(c - 1)); end
            end
            checks++;
            if (out_c !== ((c >= 1 && c <= 16) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL st_out c%0d: got %0d", c, out_c); end
            next_cycle();
        end
        req_c = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        // Store first and let it drain.
        req_b = 1'b1; wr = 1'b1; addr = 32'h50; wstrb = 4'hF; wdata = 32'hCAFEF00D;
        next_cycle();
        req_b = 1'b0; wr = 1'b0; wstrb = 4'h0;
        for (int c = 0; c < 10; c++) next_cycle();
        // Three loads in flight.
        for (int c = 0; c < 3; c++) begin
            req_b = 1'b1; addr = 32'h50 + 32'(c * 4);
            next_cycle();
        end
        req_b = 1'b0;
        next_cycle();
        checks++; if (out_b !== 3'd3) begin errors++; $display("FAIL mr_pending: got %0d expected 3", out_b); end
        reset = 1'b1;
        #1;
        checks++; if (dok_b !== 1'b0) begin errors++; $display("FAIL mr_data_ok_rst: got %b expected 0", dok_b); end
        checks++; if (out_b !== 3'd0) begin errors++; $display("FAIL mr_out_rst: got %0d expected 0", out_b); end
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL mr_addr_ok_rst: got %b expected 1", aok_b); end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++; if (dok_b !== 1'b0) begin errors++; $display("FAIL mr_dropped c%0d: got %b expected 0", c, dok_b); end
            next_cycle();
        end
        for (int c = 0; c < 10; c++) begin
            req_b = (c == 0); wr = 1'b0; addr = 32'h50;
            @(negedge clk);
            checks++;
            if (dok_b !== (c == 8)) begin errors++; $display("FAIL mr_reload_ok c%0d: got %b expected %b", c, dok_b, (c == 8)); end
            if (c == 8) begin
                checks++; if (rd_b !== 32'hCAFEF00D) begin errors++; $display("FAIL mr_persist: got %h expected cafef00d", rd_b); end
            end
            next_cycle();
        end
        req_b = 1'b0;
    endtask

    task automatic test_aliasing();
        for (int c = 0; c < 6; c++) begin
            req_a = (c < 3);
            wr    = (c == 0);
            wstrb = (c == 0) ? 4'hF : 4'h0;
            wdata = 32'hDEADBEEF;
            addr  = (c == 0) ? 32'h0000_1008 : ((c == 1) ? 32'h0000_0008 : 32'h0000_000B);
            @(negedge clk);
            checks++;
            if (dok_a !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL alias_data_ok c%0d: got %b expected %b", c, dok_a, (c >= 2 && c <= 4)); end
            if (c == 2) begin
                checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL alias_store_rsp: got %h expected 0", rd_a); end
            end
            if (c == 3 || c == 4) begin
                checks++; if (rd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_load c%0d: got %h expected deadbeef", c, rd_a); end
            end
            next_cycle();
        end
        req_a = 1'b0; wr = 1'b0; wstrb = 4'h0;
    endtask

    initial begin
        test_reset();
        test_load_roundtrip();
        test_byte_strobe();
        test_back_pressure();
        test_streaming();
        test_reset_mid_flight();
        test_aliasing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
